// File: rtl/name_display_controller_if.sv
// Byte stream handshake from the UART receive path into the name display controller.
// A byte moves on a rising edge where rx_valid and rx_ready are both high.
interface name_display_controller_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/name_display_controller.sv
// Edits a shadow copy of the displayed name from a received byte stream and commits it
// to the renderer registers only during vertical blanking, so no frame shows half-updated text.
module name_display_controller #(
  parameter int MAX_NAME_LENGTH  = 10,
  parameter int HORIZONTAL_VALID = 480,
  parameter int VERTICAL_VALID   = 272
) (
  input  logic                           tft_clock_9m,
  input  logic                           system_reset_n,
  name_display_controller_if.slave       rx_bus,
  input  logic [9:0]                     pix_y,
  output logic [8*MAX_NAME_LENGTH-1:0]   name_buffer,
  output logic [5:0]                     name_length,
  output logic [1:0]                     font_size,
  output logic                           commit_done,
  output logic                           overflow
);

  typedef enum logic [1:0] {
    EDIT       = 2'd0,
    WAIT_BLANK = 2'd1,
    COMMIT     = 2'd2
  } state_t;

  localparam logic [5:0] MAX_LEN       = 6'(MAX_NAME_LENGTH);
  localparam logic [9:0] V_BLANK_START = 10'(VERTICAL_VALID);

  // Characters per line at each scale (glyph width is 8*scale pixels), saturated to the length field.
  localparam int RAW_LIMIT_0 = HORIZONTAL_VALID / 8;
  localparam int RAW_LIMIT_1 = HORIZONTAL_VALID / 16;
  localparam int RAW_LIMIT_2 = HORIZONTAL_VALID / 24;
  localparam int RAW_LIMIT_3 = HORIZONTAL_VALID / 32;
  localparam logic [5:0] LIMIT_0 = (RAW_LIMIT_0 > 63) ? 6'd63 : 6'(RAW_LIMIT_0);
  localparam logic [5:0] LIMIT_1 = (RAW_LIMIT_1 > 63) ? 6'd63 : 6'(RAW_LIMIT_1);
  localparam logic [5:0] LIMIT_2 = (RAW_LIMIT_2 > 63) ? 6'd63 : 6'(RAW_LIMIT_2);
  localparam logic [5:0] LIMIT_3 = (RAW_LIMIT_3 > 63) ? 6'd63 : 6'(RAW_LIMIT_3);

  state_t     state_reg;
  logic       rx_ready_reg;
  logic [5:0] shadow_len_reg;
  logic [1:0] pending_font_reg;
  logic [5:0] name_length_reg;
  logic [1:0] font_size_reg;
  logic       commit_done_reg;
  logic       overflow_reg;

  logic       edit_accept;
  logic       is_printable;
  logic       is_backspace;
  logic       is_escape;
  logic       is_font;
  logic       is_commit;
  logic       shadow_full;
  logic       in_blanking;
  logic       commit_load;
  logic [5:0] visible_limit;
  logic [5:0] visible_length;

  always_comb begin
    edit_accept  = rx_bus.rx_valid && rx_ready_reg && (state_reg == EDIT);
    is_printable = (rx_bus.rx_data == 8'h20) || (rx_bus.rx_data == 8'h2B) ||
                   (rx_bus.rx_data == 8'h2D) ||
                   ((rx_bus.rx_data >= 8'h41) && (rx_bus.rx_data <= 8'h5A)) ||
                   ((rx_bus.rx_data >= 8'h61) && (rx_bus.rx_data <= 8'h7A));
    is_backspace = (rx_bus.rx_data == 8'h08);
    is_escape    = (rx_bus.rx_data == 8'h1B);
    is_font      = (rx_bus.rx_data >= 8'h11) && (rx_bus.rx_data <= 8'h14);
    is_commit    = (rx_bus.rx_data == 8'h0D) || (rx_bus.rx_data == 8'h0A);
    shadow_full  = (shadow_len_reg >= MAX_LEN);
    in_blanking  = (pix_y >= V_BLANK_START);
    commit_load  = (state_reg == COMMIT);
  end

  always_comb begin
    case (pending_font_reg)
      2'd0:    visible_limit = LIMIT_0;
      2'd1:    visible_limit = LIMIT_1;
      2'd2:    visible_limit = LIMIT_2;
      default: visible_limit = LIMIT_3;
    endcase
    visible_length = (shadow_len_reg < visible_limit) ? shadow_len_reg : visible_limit;
  end

  // Each character slot owns its shadow and active byte; only the slot addressed by the
  // current length is written, so the shadow stays a plain register file.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_NAME_LENGTH; gi++) begin : g_slot
      logic [7:0] shadow_slot_reg;
      logic [7:0] shadow_slot_next;
      logic [7:0] active_slot_reg;

      always_comb begin
        shadow_slot_next = shadow_slot_reg;
        if (edit_accept) begin
          if (is_escape) begin
            shadow_slot_next = 8'h00;
          end else if (is_printable && !shadow_full && (shadow_len_reg == 6'(gi))) begin
            shadow_slot_next = rx_bus.rx_data;
          end else if (is_backspace && (shadow_len_reg == 6'(gi + 1))) begin
            shadow_slot_next = 8'h00;
          end
        end
      end

      always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
        if (!system_reset_n) begin
          shadow_slot_reg <= 8'h00;
          active_slot_reg <= 8'h00;
        end else begin
          shadow_slot_reg <= shadow_slot_next;
          if (commit_load) begin
            active_slot_reg <= shadow_slot_reg;
          end
        end
      end

      assign name_buffer[8*gi +: 8] = active_slot_reg;
    end
  endgenerate

  always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_reg        <= EDIT;
      rx_ready_reg     <= 1'b0;
      shadow_len_reg   <= 6'd0;
      pending_font_reg <= 2'd0;
      name_length_reg  <= 6'd0;
      font_size_reg    <= 2'd0;
      commit_done_reg  <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      commit_done_reg <= 1'b0;
      case (state_reg)
        EDIT: begin
          rx_ready_reg <= 1'b1;
          if (edit_accept) begin
            if (is_printable) begin
              if (shadow_full) begin
                overflow_reg <= 1'b1;
              end else begin
                shadow_len_reg <= shadow_len_reg + 6'd1;
              end
            end else if (is_backspace) begin
              if (shadow_len_reg != 6'd0) begin
                shadow_len_reg <= shadow_len_reg - 6'd1;
              end
            end else if (is_escape) begin
              shadow_len_reg <= 6'd0;
            end else if (is_font) begin
              // 0x11..0x14 map to 0..3 through their low two bits minus one
              pending_font_reg <= rx_bus.rx_data[1:0] - 2'd1;
            end else if (is_commit) begin
              state_reg    <= WAIT_BLANK;
              rx_ready_reg <= 1'b0;
            end
          end
        end
        WAIT_BLANK: begin
          rx_ready_reg <= 1'b0;
          if (in_blanking) begin
            state_reg <= COMMIT;
          end
        end
        COMMIT: begin
          name_length_reg <= visible_length;
          font_size_reg   <= pending_font_reg;
          overflow_reg    <= 1'b0;
          commit_done_reg <= 1'b1;
          rx_ready_reg    <= 1'b1;
          state_reg       <= EDIT;
        end
        default: begin
          state_reg    <= EDIT;
          rx_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign rx_bus.rx_ready = rx_ready_reg;
  assign name_length     = name_length_reg;
  assign font_size       = font_size_reg;
  assign commit_done     = commit_done_reg;
  assign overflow        = overflow_reg;

endmodule

// File: tb/tb_name_display_controller.sv
// Drives two controllers (10- and 20-character buffers) with the same byte stream and
// checks them against a string-based model of the edit/commit rules.
module tb_name_display_controller;

  localparam int HV = 480;
  localparam int VV = 272;

  logic        tft_clock_9m = 1'b0;
  logic        system_reset_n = 1'b0;
  logic [9:0]  pix_y = 10'd100;
  logic [7:0]  tb_data = 8'h00;
  logic        tb_valid = 1'b0;

  logic [79:0]  nb10;
  logic [159:0] nb20;
  logic [5:0]   len10, len20;
  logic [1:0]   font10, font20;
  logic         cd10, cd20, ovf10, ovf20;

  always #5 tft_clock_9m = ~tft_clock_9m;

  name_display_controller_if bus10();
  name_display_controller_if bus20();
  assign bus10.rx_data  = tb_data;
  assign bus10.rx_valid = tb_valid;
  assign bus20.rx_data  = tb_data;
  assign bus20.rx_valid = tb_valid;

  name_display_controller #(.MAX_NAME_LENGTH(10), .HORIZONTAL_VALID(HV), .VERTICAL_VALID(VV)) dut10 (
    .tft_clock_9m(tft_clock_9m), .system_reset_n(system_reset_n), .rx_bus(bus10), .pix_y(pix_y),
    .name_buffer(nb10), .name_length(len10), .font_size(font10), .commit_done(cd10), .overflow(ovf10));

  name_display_controller #(.MAX_NAME_LENGTH(20), .HORIZONTAL_VALID(HV), .VERTICAL_VALID(VV)) dut20 (
    .tft_clock_9m(tft_clock_9m), .system_reset_n(system_reset_n), .rx_bus(bus20), .pix_y(pix_y),
    .name_buffer(nb20), .name_length(len20), .font_size(font20), .commit_done(cd20), .overflow(ovf20));

  int tests = 0;
  int fails = 0;

  // Behavioural model: the shadow name is a string per buffer size.
  string        m_name[2];
  int           m_max[2] = '{10, 20};
  int           m_font;
  bit           m_ovf[2];
  logic [159:0] m_act_buf[2];
  int           m_act_len[2];
  int           m_act_font;

  typedef struct {
    string       text;
    byte unsigned term;
    bit          ovf10;
    bit          ovf20;
    int          len10;
    int          len20;
    int          font;
    logic [31:0] low32;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] pack_name(input string s);
    logic [159:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  function automatic bit printable(input byte unsigned b);
    return (b == " ") || (b == "+") || (b == "-") ||
           ((b >= "A") && (b <= "Z")) || ((b >= "a") && (b <= "z"));
  endfunction

  task automatic model_reset();
    m_font = 0;
    m_act_font = 0;
    for (int k = 0; k < 2; k++) begin
      m_name[k] = "";
      m_ovf[k] = 1'b0;
      m_act_buf[k] = '0;
      m_act_len[k] = 0;
    end
  endtask

  task automatic model_byte(input byte unsigned b, output bit is_commit);
    is_commit = (b == 8'h0D) || (b == 8'h0A);
    if ((b >= 8'h11) && (b <= 8'h14)) m_font = int'(b) - 8'h11;
    for (int k = 0; k < 2; k++) begin
      if (printable(b)) begin
        if (m_name[k].len() < m_max[k]) m_name[k] = $sformatf("%s%c", m_name[k], b);
        else m_ovf[k] = 1'b1;
      end else if (b == 8'h08) begin
        if (m_name[k].len() == 1) m_name[k] = "";
        else if (m_name[k].len() > 1) m_name[k] = m_name[k].substr(0, m_name[k].len() - 2);
      end else if (b == 8'h1B) begin
        m_name[k] = "";
      end
    end
  endtask

  task automatic model_commit();
    int lim;
    lim = HV / (8 * (m_font + 1));
    m_act_font = m_font;
    for (int k = 0; k < 2; k++) begin
      m_act_buf[k] = pack_name(m_name[k]);
      m_act_len[k] = (m_name[k].len() < lim) ? m_name[k].len() : lim;
      m_ovf[k] = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".buf10"}, {80'b0, nb10}, m_act_buf[0]);
    check({tag, ".buf20"}, nb20, m_act_buf[1]);
    check({tag, ".len10"}, 160'(len10), 160'(m_act_len[0]));
    check({tag, ".len20"}, 160'(len20), 160'(m_act_len[1]));
    check({tag, ".font"}, 160'({font20, font10}), 160'({2'(m_act_font), 2'(m_act_font)}));
    check({tag, ".ovf"}, 160'({ovf20, ovf10}), 160'({m_ovf[1], m_ovf[0]}));
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input byte unsigned b, output bit is_commit);
    int waitc;
    waitc = 0;
    is_commit = 1'b0;
    tb_data = b;
    tb_valid = 1'b1;
    while (!(bus10.rx_ready && bus20.rx_ready) && (waitc < 50)) begin
      @(negedge tft_clock_9m);
      waitc++;
    end
    if (waitc >= 50) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: byte %02h never accepted, rx_ready=%b/%b required 1", b, bus10.rx_ready, bus20.rx_ready);
      tb_valid = 1'b0;
      return;
    end
    @(posedge tft_clock_9m);
    #1 tb_valid = 1'b0;
    model_byte(b, is_commit);
    $display("[TB] byte %02h accepted after %0d wait cycles", b, waitc);
    @(negedge tft_clock_9m);
  endtask

  // Called at a negedge where blanking has just become visible to a WAIT_BLANK controller.
  task automatic do_commit(input string tag);
    int c;
    bit seen;
    c = 0;
    seen = 1'b0;
    while (!seen && (c < 40)) begin
      @(posedge tft_clock_9m);
      #1 c++;
      if (cd10 || cd20) seen = 1'b1;
    end
    check({tag, ".commit_seen"}, 160'(seen), 160'(1));
    check({tag, ".commit_both"}, 160'({cd20, cd10}), 160'(2'b11));
    check({tag, ".latency"}, 160'(c), 160'(2));
    model_commit();
    check_outputs({tag, ".active"});
    check({tag, ".ready_back"}, 160'({bus20.rx_ready, bus10.rx_ready}), 160'(2'b11));
    @(posedge tft_clock_9m);
    #1 check({tag, ".pulse_end"}, 160'({cd20, cd10}), 160'(0));
    @(negedge tft_clock_9m);
  endtask

  task automatic send_string(input string s);
    bit cm;
    for (int i = 0; i < s.len(); i++) send_byte(s[i], cm);
  endtask

  initial begin
    bit cm;
    string pool;
    byte unsigned others[12];
    byte unsigned b;
    int r;

    others = '{8'h00, 8'h07, 8'h30, 8'h7F, 8'hFF, 8'h21, 8'h5B, 8'h40, 8'h09, 8'h10, 8'h15, 8'h7B};
    pool = "AZazMm +-Qq";

    vecs[0] = '{"\033\021AB\010C", 8'h0D, 1'b0, 1'b0, 2, 2, 0, 32'h00004341};
    vecs[1] = '{"\033\024ABCDEFGHIJKLMNOPQRST", 8'h0D, 1'b1, 1'b0, 10, 15, 3, 32'h44434241};
    vecs[2] = '{"\033\021Hi\033Yo\007", 8'h0A, 1'b0, 1'b0, 2, 2, 0, 32'h00006F59};
    vecs[3] = '{"\033\022Bob Smith-Jones", 8'h0D, 1'b1, 1'b0, 10, 15, 1, 32'h20626F42};
    vecs[4] = '{"\033\023AAAAAAAAAAAAAAAAAAAAA", 8'h0D, 1'b1, 1'b1, 10, 20, 2, 32'h41414141};
    vecs[5] = '{"\033\010\010Z", 8'h0D, 1'b0, 1'b0, 1, 1, 2, 32'h0000005A};
    vecs[6] = '{"\033\021", 8'h0A, 1'b0, 1'b0, 0, 0, 0, 32'h00000000};

    model_reset();

    // Reset state and release
    repeat (3) @(negedge tft_clock_9m);
    check_outputs("reset");
    check("reset.ready", 160'({bus20.rx_ready, bus10.rx_ready}), 160'(0));
    check("reset.commit_done", 160'({cd20, cd10}), 160'(0));
    system_reset_n = 1'b1;
    #1 check("release.ready_low", 160'({bus20.rx_ready, bus10.rx_ready}), 160'(0));
    @(posedge tft_clock_9m);
    #1 check("release.ready_high", 160'({bus20.rx_ready, bus10.rx_ready}), 160'(2'b11));
    @(negedge tft_clock_9m);

    // "Bob\r" outside blanking: nothing visible changes until blanking starts
    pix_y = 10'd100;
    send_string("Bob\015");
    for (int i = 0; i < 5; i++) begin
      @(negedge tft_clock_9m);
      check("bob.hold_ready", 160'({bus20.rx_ready, bus10.rx_ready}), 160'(0));
      check("bob.hold_done", 160'({cd20, cd10}), 160'(0));
      check("bob.hold_buf", {80'b0, nb10}, 160'(0));
    end
    pix_y = 10'(VV);
    do_commit("bob");
    check("bob.word", 160'(nb10[23:0]), 160'(24'h626F42));
    check("bob.len", 160'(len10), 160'(3));

    // Table of edit sequences, each committed during blanking
    pix_y = 10'd300;
    for (int v = 0; v < 7; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      for (int i = 0; i < vecs[v].text.len(); i++) begin
        send_byte(vecs[v].text[i], cm);
        check({tag, ".ready_edit"}, 160'({bus20.rx_ready, bus10.rx_ready}), 160'(2'b11));
      end
      check({tag, ".ovf_before"}, 160'({ovf20, ovf10}), 160'({vecs[v].ovf20, vecs[v].ovf10}));
      tb_data = vecs[v].term;
      tb_valid = 1'b1;
      @(posedge tft_clock_9m);
      #1 tb_valid = 1'b0;
      model_byte(vecs[v].term, cm);
      $display("[TB] byte %02h accepted as commit", vecs[v].term);
      // Blanking already active: commit_done must appear on the second edge after acceptance
      @(posedge tft_clock_9m);
      #1 check({tag, ".early_done"}, 160'({cd20, cd10}), 160'(0));
      @(posedge tft_clock_9m);
      #1 check({tag, ".done_at_n2"}, 160'({cd20, cd10}), 160'(2'b11));
      model_commit();
      check_outputs(tag);
      check({tag, ".len10_tbl"}, 160'(len10), 160'(vecs[v].len10));
      check({tag, ".len20_tbl"}, 160'(len20), 160'(vecs[v].len20));
      check({tag, ".font_tbl"}, 160'(font20), 160'(vecs[v].font));
      check({tag, ".low32_10"}, 160'(nb10[31:0]), 160'(vecs[v].low32));
      check({tag, ".low32_20"}, 160'(nb20[31:0]), 160'(vecs[v].low32));
      check({tag, ".ovf_after"}, 160'({ovf20, ovf10}), 160'(0));
      @(posedge tft_clock_9m);
      #1 check({tag, ".single_pulse"}, 160'({cd20, cd10}), 160'(0));
      @(negedge tft_clock_9m);
    end
    check("vec5.slot2_clear", 160'(nb10[23:16]), 160'(0));

    // Reset while waiting for blanking discards the commit
    pix_y = 10'd100;
    send_string("\033Q\015");
    repeat (2) @(negedge tft_clock_9m);
    #2 system_reset_n = 1'b0;
    #1 model_reset();
    check_outputs("midreset");
    check("midreset.ready", 160'({bus20.rx_ready, bus10.rx_ready}), 160'(0));
    pix_y = 10'(VV + 5);
    for (int i = 0; i < 4; i++) begin
      @(negedge tft_clock_9m);
      check("midreset.no_done", 160'({cd20, cd10}), 160'(0));
    end
    system_reset_n = 1'b1;
    #1 check("midrelease.ready_low", 160'({bus20.rx_ready, bus10.rx_ready}), 160'(0));
    @(posedge tft_clock_9m);
    #1 check("midrelease.ready_high", 160'({bus20.rx_ready, bus10.rx_ready}), 160'(2'b11));
    for (int i = 0; i < 3; i++) begin
      @(negedge tft_clock_9m);
      check("midrelease.no_done", 160'({cd20, cd10}), 160'(0));
    end
    check_outputs("midrelease");

    // Randomised stream against the model
    for (int n = 0; n < 300; n++) begin
      bit blank;
      r = int'($urandom_range(0, 99));
      if (r < 50 || r >= 92) b = pool[$urandom_range(0, pool.len() - 1)];
      else if (r < 60) b = 8'h08;
      else if (r < 64) b = 8'h1B;
      else if (r < 72) b = 8'(8'h11 + $urandom_range(0, 3));
      else if (r < 84) b = others[$urandom_range(0, 11)];
      else b = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
      blank = ($urandom_range(0, 1) == 1);
      pix_y = blank ? 10'(VV + $urandom_range(0, 10)) : 10'($urandom_range(0, VV - 1));
      if (b == 8'h0D || b == 8'h0A) begin
        tb_data = b;
        tb_valid = 1'b1;
        @(posedge tft_clock_9m);
        #1 tb_valid = 1'b0;
        model_byte(b, cm);
        $display("[TB] byte %02h accepted as commit, pix_y=%0d", b, pix_y);
        if (blank) begin
          @(posedge tft_clock_9m);
          #1 check("rnd.early_done", 160'({cd20, cd10}), 160'(0));
          @(posedge tft_clock_9m);
          #1 check("rnd.done", 160'({cd20, cd10}), 160'(2'b11));
          model_commit();
          check_outputs("rnd.commit");
          @(posedge tft_clock_9m);
          #1 check("rnd.single_pulse", 160'({cd20, cd10}), 160'(0));
          @(negedge tft_clock_9m);
        end else begin
          @(negedge tft_clock_9m);
          for (int w = 0; w < int'($urandom_range(1, 4)); w++) begin
            @(negedge tft_clock_9m);
            check("rnd.wait_done", 160'({cd20, cd10}), 160'(0));
            check("rnd.wait_ready", 160'({bus20.rx_ready, bus10.rx_ready}), 160'(0));
          end
          check_outputs("rnd.wait");
          pix_y = 10'(VV);
          do_commit("rnd");
        end
      end else begin
        send_byte(b, cm);
        check("rnd.ready", 160'({bus20.rx_ready, bus10.rx_ready}), 160'(2'b11));
        check_outputs("rnd.edit");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
